// File: rtl/hazard_fwd_unit.sv
// Bypass select and load-use/memory-wait interlock: selects are combinational (0 cycles), stall count registered.
// Backpressure: o_stall holds PC and IF/ID, o_bubble kills ID/EX; a memory wait freezes everything without a bubble.
module hazard_fwd_unit #(
    parameter  int N_REG        = 32,
    parameter  int N_SRC        = 2,
    parameter  int N_STAGES     = 3,
    parameter  int LOAD_LATENCY = 1,
    parameter  int NB_STALL_CNT = 16,
    localparam int NB_IDX       = $clog2(N_REG),
    localparam int NB_SEL       = $clog2(N_STAGES + 1)
) (
    input  logic                         i_clock,
    input  logic                         i_reset_n,
    input  logic                         i_dec_valid,
    input  logic [N_SRC*NB_IDX-1:0]      i_src_index,
    input  logic [N_STAGES-1:0]          i_stage_write,
    input  logic [N_STAGES*NB_IDX-1:0]   i_stage_regdest,
    input  logic                         i_exe_mem_read,
    input  logic                         i_mem_busy,
    input  logic                         i_flush,
    output logic [N_SRC*NB_SEL-1:0]      o_src_select,
    output logic                         o_stall,
    output logic                         o_bubble,
    output logic [NB_STALL_CNT-1:0]      o_stall_count
);

    localparam int NB_CNT = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STALL    = 2'd1,
        ST_WAIT_MEM = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [NB_CNT-1:0]        cnt_q, cnt_d;
    logic [NB_STALL_CNT-1:0]  stall_cnt_q, stall_cnt_d;

    logic [NB_IDX-1:0]        ld_dest;
    logic                     src_hit;
    logic                     hazard;
    logic                     hazard_live;

    // Scan from the oldest stage down so the youngest matching writer wins.
    always_comb begin
        o_src_select = '0;
        for (int k = 0; k < N_SRC; k++) begin
            for (int j = N_STAGES - 1; j >= 0; j--) begin
                if (i_stage_write[j]
                    && (i_src_index[k*NB_IDX +: NB_IDX] != '0)
                    && (i_stage_regdest[j*NB_IDX +: NB_IDX] == i_src_index[k*NB_IDX +: NB_IDX])) begin
                    o_src_select[k*NB_SEL +: NB_SEL] = NB_SEL'(j + 1);
                end
            end
        end
    end

    assign ld_dest = i_stage_regdest[0 +: NB_IDX];

    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (i_src_index[k*NB_IDX +: NB_IDX] == ld_dest) begin
                src_hit = 1'b1;
            end
        end
    end

    assign hazard = i_dec_valid & i_exe_mem_read & i_stage_write[0] & (ld_dest != '0) & src_hit;

    // Reset gates the hazard so an asserted reset can only stall on a memory wait.
    assign hazard_live = hazard & ~i_flush & i_reset_n;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (i_mem_busy) begin
            state_d = ST_WAIT_MEM;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hazard && (LOAD_LATENCY > 1)) begin
                        state_d = ST_STALL;
                        cnt_d   = NB_CNT'(LOAD_LATENCY - 1);
                    end
                end
                ST_STALL: begin
                    if (cnt_q == NB_CNT'(1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - NB_CNT'(1);
                    end
                end
                ST_WAIT_MEM: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        o_stall  = ((state_q == ST_IDLE) & hazard_live) | (state_q == ST_STALL) | i_mem_busy;
        o_bubble = o_stall & ~i_mem_busy;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (o_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + NB_STALL_CNT'(1);
        end
    end

    assign o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed and random stimulus for hazard_fwd_unit against a cycle-count reference model.
module tb_hazard_fwd_unit;

    localparam int LL      = 3;
    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [4:0]  src [2];
    logic [2:0]  we;
    logic [4:0]  rd [3];
    logic        mem_read;
    logic        busy;
    logic        flush;

    logic [9:0]  src_bus;
    logic [14:0] rd_bus;
    logic [3:0]  sel_bus;
    logic        stall;
    logic        bubble;
    logic [3:0]  scnt;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining stall cycles, memory-wait flag, stalled-cycle tally.
    int m_rem;
    int m_wait;
    int m_cnt;

    assign src_bus = {src[1], src[0]};
    assign rd_bus  = {rd[2], rd[1], rd[0]};

    always #5 clk = ~clk;

    hazard_fwd_unit #(
        .N_REG        (32),
        .N_SRC        (2),
        .N_STAGES     (3),
        .LOAD_LATENCY (LL),
        .NB_STALL_CNT (4)
    ) dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .i_dec_valid     (dec_valid),
        .i_src_index     (src_bus),
        .i_stage_write   (we),
        .i_stage_regdest (rd_bus),
        .i_exe_mem_read  (mem_read),
        .i_mem_busy      (busy),
        .i_flush         (flush),
        .o_src_select    (sel_bus),
        .o_stall         (stall),
        .o_bubble        (bubble),
        .o_stall_count   (scnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_sel(input int k);
        for (int j = 0; j < 3; j++) begin
            if (we[j] && (src[k] != 5'd0) && (rd[j] == src[k])) return j + 1;
        end
        return 0;
    endfunction

    function automatic bit ref_hazard();
        return dec_valid && mem_read && we[0] && (rd[0] != 5'd0)
               && ((src[0] == rd[0]) || (src[1] == rd[0]));
    endfunction

    function automatic bit ref_stall();
        bit idle;
        idle = (m_rem == 0) && (m_wait == 0);
        return (idle && ref_hazard() && !flush && rst_n) || (m_rem > 0) || busy;
    endfunction

    task automatic model_reset();
        m_rem  = 0;
        m_wait = 0;
        m_cnt  = 0;
    endtask

    task automatic model_update(input bit st);
        if (st && (m_cnt < CNT_MAX)) m_cnt++;
        if (flush) begin
            m_rem  = 0;
            m_wait = 0;
        end else if (busy) begin
            m_rem  = 0;
            m_wait = 1;
        end else if (m_wait != 0) begin
            m_wait = 0;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (ref_hazard()) begin
            m_rem = LL - 1;
        end
    endtask

    task automatic tick(input string tag);
        bit st;
        @(negedge clk);
        st = ref_stall();
        chk({tag, ":sel0"},   32'(sel_bus[1:0]), 32'(ref_sel(0)));
        chk({tag, ":sel1"},   32'(sel_bus[3:2]), 32'(ref_sel(1)));
        chk({tag, ":stall"},  32'(stall),  32'(st));
        chk({tag, ":bubble"}, 32'(bubble), 32'(st && !busy));
        chk({tag, ":count"},  32'(scnt),   32'(m_cnt));
        @(posedge clk);
        if (rst_n) model_update(st);
        #1;
    endtask

    task automatic set_idle();
        dec_valid = 1'b0;
        src[0] = '0; src[1] = '0;
        rd[0] = '0; rd[1] = '0; rd[2] = '0;
        we = '0;
        mem_read = 1'b0;
        busy = 1'b0;
        flush = 1'b0;
    endtask

    task automatic load_use_r7();
        set_idle();
        dec_valid = 1'b1;
        mem_read  = 1'b1;
        we        = 3'b001;
        rd[0]     = 5'd7;
        src[0]    = 5'd7;
    endtask

    initial begin
        set_idle();
        rst_n = 1'b0;
        model_reset();

        // Reset behaviour
        #2;
        chk("rst_stall",  32'(stall),  32'd0);
        chk("rst_bubble", 32'(bubble), 32'd0);
        chk("rst_count",  32'(scnt),   32'd0);
        busy = 1'b1;
        #1;
        chk("rst_busy_stall",  32'(stall),  32'd1);
        chk("rst_busy_bubble", 32'(bubble), 32'd0);
        busy = 1'b0;
        load_use_r7();
        #1;
        chk("rst_haz_masked", 32'(stall), 32'd0);
        tick("rst0");
        set_idle();
        tick("rst1");
        rst_n = 1'b1;
        tick("rel");

        // Forwarding priority
        dec_valid = 1'b1;
        src[0] = 5'd5; src[1] = 5'd9;
        rd[0] = 5'd5; rd[1] = 5'd5; rd[2] = 5'd9;
        we = 3'b011;
        #1;
        chk("pri_s0_stage0", 32'(sel_bus[1:0]), 32'd1);
        tick("pri_a");
        we = 3'b010;
        #1;
        chk("pri_s0_stage1", 32'(sel_bus[1:0]), 32'd2);
        tick("pri_b");
        we = 3'b100;
        #1;
        chk("pri_s0_none", 32'(sel_bus[1:0]), 32'd0);
        chk("pri_s1_stage2", 32'(sel_bus[3:2]), 32'd3);
        tick("pri_c");

        // Register zero never matches
        set_idle();
        dec_valid = 1'b1;
        mem_read  = 1'b1;
        we        = 3'b111;
        #1;
        chk("r0_sel0",  32'(sel_bus[1:0]), 32'd0);
        chk("r0_sel1",  32'(sel_bus[3:2]), 32'd0);
        chk("r0_stall", 32'(stall), 32'd0);
        tick("r0");

        // Load-use: exactly LL stall cycles
        load_use_r7();
        #1;
        chk("lu_c1_stall",  32'(stall),  32'd1);
        chk("lu_c1_bubble", 32'(bubble), 32'd1);
        tick("lu1");
        mem_read = 1'b0;
        chk("lu_c2_stall", 32'(stall), 32'd1);
        tick("lu2");
        chk("lu_c3_stall", 32'(stall), 32'd1);
        tick("lu3");
        chk("lu_c4_stall", 32'(stall), 32'd0);
        chk("lu_count",    32'(scnt),  32'd3);
        tick("lu4");

        // Memory wait arriving in STALL
        load_use_r7();
        tick("mw_det");
        mem_read = 1'b0;
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #0;
            chk("mw_stall",  32'(stall),  32'd1);
            chk("mw_bubble", 32'(bubble), 32'd0);
            tick("mw_busy");
        end
        busy = 1'b0;
        #1;
        chk("mw_release_stall", 32'(stall), 32'd0);
        tick("mw_rel");
        chk("mw_idle_stall", 32'(stall), 32'd0);
        chk("mw_count",      32'(scnt),  32'd8);
        tick("mw_idle");

        // Flush masks the hazard and aborts STALL
        load_use_r7();
        flush = 1'b1;
        #1;
        chk("fl_mask_stall", 32'(stall), 32'd0);
        tick("fl_mask");
        flush = 1'b0;
        #1;
        chk("fl_det_stall", 32'(stall), 32'd1);
        tick("fl_det");
        mem_read = 1'b0;
        flush = 1'b1;
        #1;
        chk("fl_in_stall", 32'(stall), 32'd1);
        tick("fl_in");
        flush = 1'b0;
        #1;
        chk("fl_after_stall", 32'(stall), 32'd0);
        tick("fl_after");

        // Async reset mid-STALL
        load_use_r7();
        tick("rs_det");
        mem_read = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rs_stall", 32'(stall), 32'd0);
        chk("rs_count", 32'(scnt),  32'd0);
        tick("rs_hold");
        rst_n = 1'b1;
        #1;
        chk("rs_rel_stall", 32'(stall), 32'd0);
        tick("rs_rel1");
        chk("rs_rel_stall2", 32'(stall), 32'd0);
        tick("rs_rel2");

        // Stall counter saturation
        set_idle();
        busy = 1'b1;
        for (int i = 0; i < 20; i++) tick("sat");
        busy = 1'b0;
        #1;
        chk("sat_count", 32'(scnt), 32'd15);
        tick("sat_end");

        // Randomized traffic with periodic reset pulses
        for (int c = 0; c < 400; c++) begin
            dec_valid = ($urandom_range(0, 3) != 0);
            src[0]    = 5'($urandom_range(0, 3));
            src[1]    = 5'($urandom_range(0, 3));
            rd[0]     = 5'($urandom_range(0, 3));
            rd[1]     = 5'($urandom_range(0, 3));
            rd[2]     = 5'($urandom_range(0, 3));
            we        = 3'($urandom_range(0, 7));
            mem_read  = ($urandom_range(0, 1) != 0);
            busy      = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            if ((c % 50) == 49) begin
                rst_n = 1'b0;
                model_reset();
                #2;
                rst_n = 1'b1;
            end
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
